// File: rtl/fifo_tx_feeder_pkg.sv
// Shared types and constants for the FIFO-to-UART-TX feeder.
package fifo_tx_feeder_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam int unsigned STATE_WIDTH        = 3;
   // GAP_CYCLES ranges over 0..255, so the inline gap counter is one byte wide.
   localparam int unsigned GAP_CNT_WIDTH      = 8;

   typedef enum logic [STATE_WIDTH-1:0] {
      StIdle = 3'd0,
      StLoad = 3'd1,
      StReq  = 3'd2,
      StBusy = 3'd3,
      StGap  = 3'd4
   } feeder_state_e;

endpackage

// File: rtl/fifo_tx_feeder_if.sv
// FIFO read side plus UART TX handshake seen by the feeder.
// master: the feeder itself; slave: the FIFO read stage and TX core around it.
interface fifo_tx_feeder_if
   import fifo_tx_feeder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = 8
) ();

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_rinc;
   logic                  tx_busy;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_data_valid;
   logic [CNT_WIDTH-1:0]  frames_sent;
   logic                  feeder_idle;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      input  tx_busy,
      output fifo_rinc,
      output tx_data,
      output tx_data_valid,
      output frames_sent,
      output feeder_idle
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      output tx_busy,
      input  fifo_rinc,
      input  tx_data,
      input  tx_data_valid,
      input  frames_sent,
      input  feeder_idle
   );

endinterface

// File: rtl/fifo_tx_feeder.sv
// Pops one word at a time from the async FIFO (TX clock domain), registers it and
// hands it to the UART TX core with a valid/busy handshake. The next pop waits until
// the current frame has finished plus an optional idle gap.
// A word already popped when reset is asserted is dropped; upstream accepts that loss.
module fifo_tx_feeder
   import fifo_tx_feeder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   fifo_tx_feeder_if.master  bus
);

   localparam logic [GAP_CNT_WIDTH-1:0] GAP_LOAD = GAP_CNT_WIDTH'(GAP_CYCLES - 1);

   feeder_state_e             state_q;
   logic [DATA_WIDTH-1:0]     tx_data_q;
   logic                      tx_data_valid_q;
   logic [CNT_WIDTH-1:0]      frames_sent_q;
   logic [GAP_CNT_WIDTH-1:0]  gap_cnt_q;
   logic                      pop;

   // Mealy pop: only from IDLE, only with data present and the TX core free.
   // Gated by reset so the FIFO pointer never moves while held in reset.
   assign pop = rst && (state_q == StIdle) && !bus.fifo_empty && !bus.tx_busy;

   // Feeder FSM with registered data, request and frame counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= StIdle;
         tx_data_q       <= '0;
         tx_data_valid_q <= 1'b0;
         frames_sent_q   <= '0;
         gap_cnt_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  tx_data_q <= bus.fifo_rdata;
                  state_q   <= StLoad;
               end
            end
            // Settle cycle: the gray read pointer lags the binary one, so
            // fifo_empty may still read 0 here after popping the last word.
            StLoad: begin
               tx_data_valid_q <= 1'b1;
               state_q         <= StReq;
            end
            StReq: begin
               if (bus.tx_busy) begin
                  tx_data_valid_q <= 1'b0;
                  state_q         <= StBusy;
               end
            end
            StBusy: begin
               if (!bus.tx_busy) begin
                  frames_sent_q <= frames_sent_q + CNT_WIDTH'(1);
                  if (GAP_CYCLES == 0) begin
                     state_q <= StIdle;
                  end else begin
                     gap_cnt_q <= GAP_LOAD;
                     state_q   <= StGap;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_CNT_WIDTH'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.fifo_rinc     = pop;
   assign bus.tx_data       = tx_data_q;
   assign bus.tx_data_valid = tx_data_valid_q;
   assign bus.frames_sent   = frames_sent_q;
   assign bus.feeder_idle   = (state_q == StIdle);

endmodule

// File: tb/tb_fifo_tx_feeder.sv
// Bench for fifo_tx_feeder: two instances (no gap / 8-bit count, 3-cycle gap / 2-bit
// count) fed the same word stream. Each lane has a FIFO model with a one-cycle-stale
// empty flag, a UART TX responder, and a reference of the feeder's timing rules.
module tb_fifo_tx_feeder;

   localparam int unsigned DW    = 8;
   localparam int          LANES = 2;
   localparam int          RING  = 512;
   localparam int unsigned GAP0  = 0;
   localparam int unsigned GAP1  = 3;
   localparam int unsigned CW0   = 8;
   localparam int unsigned CW1   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_tx_feeder_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW0)) bus0 ();
   fifo_tx_feeder_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW1)) bus1 ();

   fifo_tx_feeder #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP0), .CNT_WIDTH(CW0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   fifo_tx_feeder #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP1), .CNT_WIDTH(CW1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // Environment-driven signals per lane.
   logic          empty_r [LANES];
   logic [DW-1:0] rdata_r [LANES];
   logic          busy_r  [LANES];
   logic          busy_hold = 1'b0;

   assign bus0.fifo_empty = empty_r[0];
   assign bus1.fifo_empty = empty_r[1];
   assign bus0.fifo_rdata = rdata_r[0];
   assign bus1.fifo_rdata = rdata_r[1];
   assign bus0.tx_busy    = busy_r[0] | busy_hold;
   assign bus1.tx_busy    = busy_r[1] | busy_hold;

   // DUT outputs gathered per lane.
   logic          rinc_s  [LANES];
   logic          valid_s [LANES];
   logic          idle_s  [LANES];
   logic          busy_s  [LANES];
   logic [DW-1:0] data_s  [LANES];
   int            frames_s[LANES];

   assign rinc_s[0]   = bus0.fifo_rinc;
   assign rinc_s[1]   = bus1.fifo_rinc;
   assign valid_s[0]  = bus0.tx_data_valid;
   assign valid_s[1]  = bus1.tx_data_valid;
   assign idle_s[0]   = bus0.feeder_idle;
   assign idle_s[1]   = bus1.feeder_idle;
   assign busy_s[0]   = bus0.tx_busy;
   assign busy_s[1]   = bus1.tx_busy;
   assign data_s[0]   = bus0.tx_data;
   assign data_s[1]   = bus1.tx_data;
   assign frames_s[0] = int'(bus0.frames_sent);
   assign frames_s[1] = int'(bus1.frames_sent);

   // Word stream: stimulus appends at ft, FIFO model pops at fh, scoreboard at eh.
   logic [DW-1:0] word_q [LANES][RING];
   int            ft [LANES] = '{0, 0};
   int            fh [LANES] = '{0, 0};
   int            eh [LANES] = '{0, 0};

   // Reference state (owned by the monitor).
   bit            pend     [LANES];
   bit            in_frame [LANES];
   int            pop_edge [LANES];
   int            ready_edge [LANES];
   int            frames_m [LANES];
   logic [DW-1:0] cur_data [LANES];
   int            tx_st    [LANES];
   int            tx_cnt   [LANES];

   int cyc     = 0;
   int n_vec   = 0;
   int n_err   = 0;
   int stuck   = 0;
   bit fin_req = 1'b0;
   bit tx_rand = 1'b0;
   int tx_dly  = 2;
   int tx_len  = 10;

   task automatic chk(input string name, input int lane, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s lane%0d: got %0d, want %0d (cycle %0d)", name, lane, act, exp, cyc);
      end
   endtask

   function automatic int gap_of(input int l);
      return (l == 0) ? int'(GAP0) : int'(GAP1);
   endfunction

   function automatic int wrap_of(input int l);
      return (l == 0) ? (1 << CW0) : (1 << CW1);
   endfunction

   // Monitor: FIFO model, TX responder, reference timing and scoreboard.
   always @(posedge clk) begin
      if (fin_req) begin
         for (int l = 0; l < LANES; l++) chk("drained", l, ft[l] - eh[l], 0);
         chk("no_timeout", 0, stuck, 0);
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $finish;
      end
      cyc <= cyc + 1;
      for (int l = 0; l < LANES; l++) begin
         bit e_idle;
         bit e_rinc;
         bit e_valid;
         int cnt;
         int popn;
         if (!rst) begin
            chk("rst_valid", l, int'(valid_s[l]), 0);
            chk("rst_data", l, int'(data_s[l]), 0);
            chk("rst_idle", l, int'(idle_s[l]), 1);
            chk("rst_rinc", l, int'(rinc_s[l]), 0);
            chk("rst_frames", l, frames_s[l], 0);
            // A word popped but not yet accepted is lost by reset.
            if (pend[l]) eh[l] <= eh[l] + 1;
            pend[l]       <= 1'b0;
            in_frame[l]   <= 1'b0;
            ready_edge[l] <= 0;
            frames_m[l]   <= 0;
            cur_data[l]   <= '0;
            tx_st[l]      <= 0;
            tx_cnt[l]     <= 0;
            busy_r[l]     <= 1'b0;
         end else begin
            e_idle  = !pend[l] && !in_frame[l] && (cyc >= ready_edge[l]);
            e_rinc  = e_idle && !empty_r[l] && !busy_s[l];
            e_valid = pend[l] && (cyc >= pop_edge[l] + 2);
            chk("rinc", l, int'(rinc_s[l]), int'(e_rinc));
            chk("idle", l, int'(idle_s[l]), int'(e_idle));
            chk("valid", l, int'(valid_s[l]), int'(e_valid));
            chk("frames", l, frames_s[l], frames_m[l]);
            chk("tx_data", l, int'(data_s[l]), int'(cur_data[l]));
            if (in_frame[l] && !busy_s[l]) begin
               in_frame[l]   <= 1'b0;
               frames_m[l]   <= (frames_m[l] + 1) % wrap_of(l);
               ready_edge[l] <= cyc + 1 + gap_of(l);
            end
            if (e_valid && busy_s[l]) begin
               chk("sb_data", l, int'(data_s[l]), int'(word_q[l][eh[l] % RING]));
               eh[l]       <= eh[l] + 1;
               pend[l]     <= 1'b0;
               in_frame[l] <= 1'b1;
            end
            if (rinc_s[l]) begin
               pend[l]     <= 1'b1;
               pop_edge[l] <= cyc;
               cur_data[l] <= rdata_r[l];
            end
            // TX responder: busy some cycles after a request, for a frame length.
            case (tx_st[l])
               0: if (valid_s[l]) begin
                  tx_st[l]  <= 1;
                  tx_cnt[l] <= tx_rand ? int'($urandom_range(1, 3)) : tx_dly;
               end
               1: if (tx_cnt[l] <= 1) begin
                  busy_r[l] <= 1'b1;
                  tx_st[l]  <= 2;
                  tx_cnt[l] <= tx_rand ? int'($urandom_range(1, 12)) : tx_len;
               end else begin
                  tx_cnt[l] <= tx_cnt[l] - 1;
               end
               default: if (tx_cnt[l] <= 1) begin
                  busy_r[l] <= 1'b0;
                  tx_st[l]  <= 0;
               end else begin
                  tx_cnt[l] <= tx_cnt[l] - 1;
               end
            endcase
         end
         // FIFO model: empty flag reflects the count before this edge's pop.
         cnt  = ft[l] - fh[l];
         popn = (rinc_s[l] && cnt > 0) ? 1 : 0;
         if (rinc_s[l]) chk("pop_nonempty", l, int'(cnt > 0), 1);
         empty_r[l] <= (cnt == 0);
         rdata_r[l] <= (cnt - popn > 0) ? word_q[l][(fh[l] + popn) % RING] : '0;
         fh[l]      <= fh[l] + popn;
      end
   end

   task automatic push(input logic [DW-1:0] w);
      for (int l = 0; l < LANES; l++) begin
         word_q[l][ft[l] % RING] = w;
         ft[l]++;
      end
   endtask

   task automatic wait_drain(input int limit);
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (eh[0] == ft[0] && eh[1] == ft[1] && idle_s[0] && idle_s[1] &&
             !busy_s[0] && !busy_s[1]) return;
      end
      stuck++;
   endtask

   task automatic wait_valid(input int limit);
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (valid_s[0] && valid_s[1]) return;
      end
      stuck++;
   endtask

   // Stimulus.
   initial begin
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      // Empty FIFO: nothing may happen.
      repeat (50) @(negedge clk);
      // Single word with a fixed TX response.
      push(8'hA5);
      wait_drain(200);
      // Last word: empty flag is stale for one cycle after the pop.
      push(8'h11);
      wait_drain(200);
      // Burst of four.
      for (int i = 1; i <= 4; i++) push(DW'(i));
      wait_drain(400);
      // Data arrives while the TX core is busy.
      busy_hold = 1'b1;
      push(8'h5A);
      repeat (6) @(negedge clk);
      busy_hold = 1'b0;
      wait_drain(200);
      // Reset while requesting: word is lost, next one goes through.
      push(8'h3C);
      wait_valid(50);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      push(8'h7E);
      wait_drain(200);
      // Randomized traffic, TX timing and busy interference.
      tx_rand = 1'b1;
      for (int it = 0; it < 60; it++) begin
         int n;
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) push(DW'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            busy_hold = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            busy_hold = 1'b0;
         end
         repeat ($urandom_range(0, 20)) @(negedge clk);
         if ($urandom_range(0, 1) == 1) wait_drain(2000);
      end
      wait_drain(6000);
      fin_req = 1'b1;
   end

endmodule
